serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor, LSB first, one bit per clock.
//            A two-half-subtractor slice feeds a shift register; the result
//            and final borrow are published only when the operation ends.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_res;
    logic               r_bor;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    logic               w_hs1_d;
    logic               w_hs1_b;
    logic               w_hs2_d;
    logic               w_hs2_b;
    logic               w_bout;
    logic [WIDTH-2:0]   w_res_shift;

    // Bit slice: first half subtractor on a_i/b_i, second on the running borrow
    assign w_hs1_d = r_a[0] ^ r_b[0];
    assign w_hs1_b = ~r_a[0] & r_b[0];
    assign w_hs2_d = w_hs1_d ^ r_bor;
    assign w_hs2_b = ~w_hs1_d & r_bor;
    assign w_bout  = w_hs1_b | w_hs2_b;

    // Only WIDTH-1 bits are stored; the last bit goes straight into Diff
    generate
        if (WIDTH > 2) begin : g_res_wide
            assign w_res_shift = {w_hs2_d, r_res[WIDTH-2:1]};
        end else begin : g_res_narrow
            assign w_res_shift = w_hs2_d;
        end
    endgenerate

    assign w_last = (r_state == RUN) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bor    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_load) begin
            r_a   <= A;
            r_b   <= B;
            r_res <= '0;
            r_bor <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_shift;
            r_bor <= w_bout;
            if (w_last) begin
                r_cnt    <= '0;
                r_diff   <= {w_hs2_d, r_res};
                r_borrow <= w_bout;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign Diff   = r_diff;
    assign Borrow = r_borrow;

endmodule

`default_nettype wire
